// File: rtl/add_sub_pkg.sv
// Shared definitions for the registered add/subtract unit.
package add_sub_pkg;

    localparam int unsigned DefaultNumSize = 32;

    // Encoding of the add select input.
    typedef enum logic {
        OpSub = 1'b0,
        OpAdd = 1'b1
    } op_e;

    // Signed overflow is present when the carry into the sign bit and the carry out of it differ.
    function automatic logic signed_ovf(input logic c_msb_in, input logic c_out);
        return c_msb_in ^ c_out;
    endfunction

endpackage

// File: rtl/add_sub_core.sv
// Purely combinational ripple-carry adder that also exposes the carry into the MSB.
module add_sub_core #(
    parameter int unsigned NUM_SIZE = 32
) (
    input  logic [NUM_SIZE-1:0] a,
    input  logic [NUM_SIZE-1:0] b,
    input  logic                cin,
    output logic [NUM_SIZE-1:0] sum,
    output logic                cMsbIn,
    output logic                cOut
);

    logic [NUM_SIZE:0] carry;

    // Ripple the carry bit by bit so the carry into the MSB is available for the overflow flag.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < NUM_SIZE; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cMsbIn = carry[NUM_SIZE-1];
    assign cOut   = carry[NUM_SIZE];

endmodule

// File: rtl/add_sub.sv
// Registered signed two's-complement adder/subtractor with a signed-overflow flag.
// Subtraction is A + ~B + 1; the result wraps modulo 2^NUM_SIZE. NUM_SIZE must be >= 2.
module add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned NUM_SIZE = DefaultNumSize
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                add,
    input  logic [NUM_SIZE-1:0] dIn0,
    input  logic [NUM_SIZE-1:0] dIn1,
    output logic                overflow,
    output logic [NUM_SIZE-1:0] dOut
);

    logic [NUM_SIZE-1:0] b_eff;
    logic                cin;
    logic [NUM_SIZE-1:0] sum;
    logic                c_msb_in;
    logic                c_out;

    // Invert operand B and inject a carry for subtraction.
    always_comb begin
        if (op_e'(add) == OpAdd) begin
            b_eff = dIn1;
            cin   = 1'b0;
        end else begin
            b_eff = ~dIn1;
            cin   = 1'b1;
        end
    end

    add_sub_core #(
        .NUM_SIZE(NUM_SIZE)
    ) u_core (
        .a     (dIn0),
        .b     (b_eff),
        .cin   (cin),
        .sum   (sum),
        .cMsbIn(c_msb_in),
        .cOut  (c_out)
    );

    // Capture the result and overflow flag; reset clears both immediately.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dOut     <= '0;
            overflow <= 1'b0;
        end else begin
            dOut     <= sum;
            overflow <= signed_ovf(c_msb_in, c_out);
        end
    end

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub at NUM_SIZE=32 and NUM_SIZE=8.
module tb_add_sub;

    logic        clk;
    logic        rstN;
    logic        add32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        ov32;
    logic [31:0] out32;
    logic        add8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        ov8;
    logic [7:0]  out8;

    int n_checks = 0;
    int n_errors = 0;

    add_sub #(.NUM_SIZE(32)) dut32 (
        .clk     (clk),
        .rstN    (rstN),
        .add     (add32),
        .dIn0    (a32),
        .dIn1    (b32),
        .overflow(ov32),
        .dOut    (out32)
    );

    add_sub #(.NUM_SIZE(8)) dut8 (
        .clk     (clk),
        .rstN    (rstN),
        .add     (add8),
        .dIn0    (a8),
        .dIn1    (b8),
        .overflow(ov8),
        .dOut    (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: returns {overflow, sum} for a w-bit operation using the sign rule.
    function automatic logic [32:0] ref_op(input int unsigned w, input logic op_add,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bm;
        logic [63:0] full;
        logic [31:0] s;
        logic        sa;
        logic        sb;
        logic        ss;
        logic        ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = a & mask;
        bm   = b & mask;
        if (op_add) full = {32'h0, am} + {32'h0, bm};
        else        full = {32'h0, am} - {32'h0, bm};
        s  = full[31:0] & mask;
        sa = am[w-1];
        sb = bm[w-1];
        ss = s[w-1];
        if (op_add) ov = (sa == sb) && (ss != sa);
        else        ov = (sa != sb) && (ss != sa);
        return {ov, s};
    endfunction

    task automatic op32(input string tag, input logic op_add, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_ov);
        add32 = op_add;
        a32   = a;
        b32   = b;
        @(posedge clk);
        #1;
        check({tag, ".dOut"}, out32, exp);
        check({tag, ".ovf"}, {31'h0, ov32}, {31'h0, exp_ov});
    endtask

    task automatic op8(input string tag, input logic op_add, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp, input logic exp_ov);
        add8 = op_add;
        a8   = a;
        b8   = b;
        @(posedge clk);
        #1;
        check({tag, ".dOut8"}, {24'h0, out8}, {24'h0, exp});
        check({tag, ".ovf8"}, {31'h0, ov8}, {31'h0, exp_ov});
    endtask

    function automatic logic [31:0] pick32();
        logic [31:0] r;
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h8000_0000;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'hFFFF_FFFF;
        edges[4] = 32'h0000_0001;
        r = $urandom();
        if ($urandom_range(0, 3) == 0) r = edges[$urandom_range(0, 4)];
        return r;
    endfunction

    initial begin
        logic [32:0] exp32;
        logic [32:0] exp8;
        logic [32:0] prev32;
        logic [32:0] prev8;
        logic [31:0] r;

        rstN  = 1'b1;
        add32 = 1'b1;
        a32   = 32'h1234_5678;
        b32   = 32'h0FED_CBA9;
        add8  = 1'b1;
        a8    = 8'h55;
        b8    = 8'h22;
        #1;
        rstN = 1'b0;

        // Operands are live but reset holds the outputs at zero across edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst.dOut", out32, 32'h0);
        check("rst.ovf", {31'h0, ov32}, 32'h0);
        check("rst.dOut8", {24'h0, out8}, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        op32("add_5_7",     1'b1, 32'd5,         32'd7,         32'd12,        1'b0);
        op32("add_m1_m1",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        op32("sub_5_7",     1'b0, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0);
        op32("sub_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b0);
        op32("add_max_1",   1'b1, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1);
        op32("add_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        op32("sub_min_1",   1'b0, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1);
        op32("add_max_min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        op32("sub_max_m1",  1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        op32("sub_0_min",   1'b0, 32'h0,         32'h8000_0000, 32'h8000_0000, 1'b1);

        op8("b_sub_0_min",   1'b0, 8'h00, 8'h80, 8'h80, 1'b1);
        op8("b_add_max_1",   1'b1, 8'h7F, 8'h01, 8'h80, 1'b1);
        op8("b_add_max_min", 1'b1, 8'h7F, 8'h80, 8'hFF, 1'b0);
        op8("b_sub_min_min", 1'b0, 8'h80, 8'h80, 8'h00, 1'b0);
        op8("b_add_3_m2",    1'b1, 8'h03, 8'hFE, 8'h01, 1'b0);

        // Mid-stream reset pulse between edges: outputs must clear without a clock edge.
        check("pre_rst.dOut", out32, 32'h8000_0000);
        rstN = 1'b0;
        #1;
        check("async_rst.dOut", out32, 32'h0);
        check("async_rst.ovf", {31'h0, ov32}, 32'h0);
        add32 = 1'b1;
        a32   = 32'd5;
        b32   = 32'd7;
        #2;
        rstN = 1'b1;
        #1;
        check("rst_released.dOut", out32, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst.dOut", out32, 32'd12);
        check("post_rst.ovf", {31'h0, ov32}, 32'h0);

        // Back-to-back random ops on both widths; outputs must hold until the next edge.
        prev32 = 33'h0;
        prev8  = 33'h0;
        for (int i = 0; i < 1000; i++) begin
            add32 = 1'($urandom_range(0, 1));
            a32   = pick32();
            b32   = pick32();
            add8  = 1'($urandom_range(0, 1));
            r     = pick32();
            a8    = r[7:0];
            r     = pick32();
            b8    = r[7:0];
            exp32 = ref_op(32, add32, a32, b32);
            exp8  = ref_op(8, add8, {24'h0, a8}, {24'h0, b8});
            #1;
            if (i > 0) begin
                check("hold.dOut", out32, prev32[31:0]);
                check("hold.dOut8", {24'h0, out8}, prev8[31:0]);
            end
            @(posedge clk);
            #1;
            check("rnd.dOut", out32, exp32[31:0]);
            check("rnd.ovf", {31'h0, ov32}, {31'h0, exp32[32]});
            check("rnd.dOut8", {24'h0, out8}, exp8[31:0]);
            check("rnd.ovf8", {31'h0, ov8}, {31'h0, exp8[32]});
            prev32 = exp32;
            prev8  = exp8;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
